jk_bank_arbiter: RTL and testbench

Round-robin command arbiter and sequencer for a bank of `WIDTH` JK flip-flops sharing one clock.
- Up to `NUM_REQ` requesters each post a single-bit command: hold, clear, set or toggle, encoded as {J,K}.
- The block grants one request at a time and drives one-hot J/K vectors onto the bank for exactly one cycle.
- It inserts a programmable settle gap between commands.
- It keeps a shadow copy of the bank state, which can be resynchronised from the bank's real outputs.

---
 rtl/jk_bank_arbiter_if.sv | 29 ++
 rtl/jk_bank_arbiter.sv | 154 +++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_arbiter_if.sv
// Request/command bus between requesters and the JK bank arbiter, plus the bank-facing
// J/K drive and Q feedback.
interface jk_bank_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     cmd;
  logic [IDX_W*NUM_REQ-1:0] index;
  logic                     resync;
  logic [WIDTH-1:0]         bank_q;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         signal_j;
  logic [WIDTH-1:0]         signal_k;
  logic [WIDTH-1:0]         shadow;
  logic                     busy;
  logic                     err;

  modport master (
    output req, cmd, index, resync, bank_q,
    input  ack, signal_j, signal_k, shadow, busy, err
  );

  modport slave (
    input  req, cmd, index, resync, bank_q,
    output ack, signal_j, signal_k, shadow, busy, err
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that issues one-hot JK commands to a flip-flop bank, one per
// 2+GAP_CYCLES cycles, while tracking a shadow copy of the bank state.
module jk_bank_arbiter #(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 3,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic            i_CLOCK_POS,
  input logic            i_RESET_NEG,
  jk_bank_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   WIDTH_L  = (IDX_W+1)'(WIDTH);
  localparam logic [PTR_W-1:0] LAST_ID  = PTR_W'(NUM_REQ - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_id_q, win_id_d;
  logic [1:0]         win_cmd_q, win_cmd_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [3:0]         gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic               err_q, err_d;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [1:0]         pick_cmd;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_ok, win_ok;
  logic [WIDTH-1:0]   base, mask;

  // Two passes give the wrap-around search: first ids at or above rr_ptr, then from 0.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pick_cmd = '0;
    pick_idx = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!found && bus.req[r] && (r >= int'(rr_ptr_q))) begin
        found    = 1'b1;
        pick     = PTR_W'(r);
        pick_cmd = bus.cmd[2*r +: 2];
        pick_idx = bus.index[IDX_W*r +: IDX_W];
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!found && bus.req[r]) begin
        found    = 1'b1;
        pick     = PTR_W'(r);
        pick_cmd = bus.cmd[2*r +: 2];
        pick_idx = bus.index[IDX_W*r +: IDX_W];
      end
    end
  end

  assign pick_ok = ({1'b0, pick_idx} < WIDTH_L);
  assign win_ok  = ({1'b0, win_idx_q} < WIDTH_L);
  assign base    = bus.resync ? bus.bank_q : shadow_q;
  assign mask    = WIDTH'(1) << win_idx_q;

  // NOTE: every output of this block is assigned a default first so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_id_d  = win_id_q;
    win_cmd_d = win_cmd_q;
    win_idx_d = win_idx_q;
    gap_d     = gap_q;
    ack_d     = '0;
    j_d       = '0;
    k_d       = '0;
    err_d     = 1'b0;
    shadow_d  = base;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = ISSUE;
          win_id_d  = pick;
          win_cmd_d = pick_cmd;
          win_idx_d = pick_idx;
          ack_d     = NUM_REQ'(1) << pick;
          if (pick_ok) begin
            j_d = WIDTH'(pick_cmd[1]) << pick_idx;
            k_d = WIDTH'(pick_cmd[0]) << pick_idx;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        rr_ptr_d = (win_id_q == LAST_ID) ? '0 : win_id_q + PTR_W'(1);
        state_d  = (GAP_CYCLES > 0) ? GAP : IDLE;
        gap_d    = GAP_LOAD;
        if (win_ok) begin
          case (win_cmd_q)
            2'b01:   shadow_d = base & ~mask;
            2'b10:   shadow_d = base | mask;
            2'b11:   shadow_d = base ^ mask;
            default: shadow_d = base;
          endcase
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge i_CLOCK_POS) begin
    if (!i_RESET_NEG) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_id_q  <= '0;
      win_cmd_q <= '0;
      win_idx_q <= '0;
      gap_q     <= '0;
      ack_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      shadow_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_id_q  <= win_id_d;
      win_cmd_q <= win_cmd_d;
      win_idx_q <= win_idx_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      j_q       <= j_d;
      k_q       <= k_d;
      shadow_q  <= shadow_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.signal_j = j_q;
  assign bus.signal_k = k_q;
  assign bus.shadow   = shadow_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: a cycle table on the default configuration, plus
// sequences for round robin, out-of-range index (WIDTH=6) and reset mid-gap (GAP_CYCLES=5).
module tb_jk_bank_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.WIDTH(8), .IDX_W(3), .NUM_REQ(4)) bus_a ();
  jk_bank_arbiter_if #(.WIDTH(6), .IDX_W(3), .NUM_REQ(4)) bus_b ();
  jk_bank_arbiter_if #(.WIDTH(8), .IDX_W(3), .NUM_REQ(4)) bus_c ();

  jk_bank_arbiter #(.WIDTH(8), .IDX_W(3), .NUM_REQ(4), .GAP_CYCLES(1)) u_a (
    .i_CLOCK_POS(clk), .i_RESET_NEG(rst_n), .bus(bus_a));
  jk_bank_arbiter #(.WIDTH(6), .IDX_W(3), .NUM_REQ(4), .GAP_CYCLES(1)) u_b (
    .i_CLOCK_POS(clk), .i_RESET_NEG(rst_n), .bus(bus_b));
  jk_bank_arbiter #(.WIDTH(8), .IDX_W(3), .NUM_REQ(4), .GAP_CYCLES(5)) u_c (
    .i_CLOCK_POS(clk), .i_RESET_NEG(rst_n), .bus(bus_c));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs applied during one cycle, and the outputs expected in the following cycle.
  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [11:0] index;
    logic        resync;
    logic [7:0]  bank_q;
    logic [3:0]  ack;
    logic [7:0]  j;
    logic [7:0]  k;
    logic [7:0]  shadow;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [3:0] exp_ack;
    logic [7:0] exp_j;

    vecs[0]  = '{4'h1, 8'h02, 12'h003, 1'b0, 8'h00, 4'h1, 8'h08, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{4'h1, 8'h02, 12'h003, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h08, 1'b1, 1'b0};
    vecs[2]  = '{4'h0, 8'h00, 12'h000, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0};
    vecs[3]  = '{4'h0, 8'h00, 12'h000, 1'b1, 8'hFF, 4'h0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{4'h1, 8'h03, 12'h000, 1'b0, 8'h00, 4'h1, 8'h01, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{4'h1, 8'h03, 12'h000, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'hFE, 1'b1, 1'b0};
    vecs[6]  = '{4'h1, 8'h01, 12'h007, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b0};
    vecs[7]  = '{4'h1, 8'h01, 12'h007, 1'b0, 8'h00, 4'h1, 8'h00, 8'h80, 8'hFE, 1'b1, 1'b0};
    vecs[8]  = '{4'h1, 8'h01, 12'h007, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h7E, 1'b1, 1'b0};
    vecs[9]  = '{4'h0, 8'h00, 12'h000, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h7E, 1'b0, 1'b0};
    vecs[10] = '{4'h0, 8'h00, 12'h000, 1'b1, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{4'h1, 8'h03, 12'h000, 1'b0, 8'h00, 4'h1, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{4'h1, 8'h03, 12'h000, 1'b1, 8'hF0, 4'h0, 8'h00, 8'h00, 8'hF1, 1'b1, 1'b0};
    vecs[13] = '{4'h0, 8'h00, 12'h000, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'hF1, 1'b0, 1'b0};
    vecs[14] = '{4'h2, 8'h00, 12'h010, 1'b0, 8'h00, 4'h2, 8'h00, 8'h00, 8'hF1, 1'b1, 1'b0};
    vecs[15] = '{4'h2, 8'h00, 12'h010, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'hF1, 1'b1, 1'b0};
    vecs[16] = '{4'h0, 8'h00, 12'h000, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'hF1, 1'b0, 1'b0};

    bus_a.req = '0; bus_a.cmd = '0; bus_a.index = '0; bus_a.resync = 1'b0; bus_a.bank_q = '0;
    bus_b.req = '0; bus_b.cmd = '0; bus_b.index = '0; bus_b.resync = 1'b0; bus_b.bank_q = '0;
    bus_c.req = '0; bus_c.cmd = '0; bus_c.index = '0; bus_c.resync = 1'b0; bus_c.bank_q = '0;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    check("reset ack",    32'(bus_a.ack),      32'h0);
    check("reset j",      32'(bus_a.signal_j), 32'h0);
    check("reset k",      32'(bus_a.signal_k), 32'h0);
    check("reset shadow", 32'(bus_a.shadow),   32'h0);
    check("reset busy",   32'(bus_a.busy),     32'h0);
    check("reset err",    32'(bus_a.err),      32'h0);
    rst_n = 1'b1;

    // Single set, toggle/clear, resync during issue, hold command
    for (int i = 0; i < 17; i++) begin
      bus_a.req    = vecs[i].req;
      bus_a.cmd    = vecs[i].cmd;
      bus_a.index  = vecs[i].index;
      bus_a.resync = vecs[i].resync;
      bus_a.bank_q = vecs[i].bank_q;
      tick();
      check($sformatf("row%0d ack", i),    32'(bus_a.ack),      32'(vecs[i].ack));
      check($sformatf("row%0d j", i),      32'(bus_a.signal_j), 32'(vecs[i].j));
      check($sformatf("row%0d k", i),      32'(bus_a.signal_k), 32'(vecs[i].k));
      check($sformatf("row%0d shadow", i), 32'(bus_a.shadow),   32'(vecs[i].shadow));
      check($sformatf("row%0d busy", i),   32'(bus_a.busy),     32'(vecs[i].busy));
      check($sformatf("row%0d err", i),    32'(bus_a.err),      32'(vecs[i].err));
    end

    // Round robin from a fresh reset: each requester sets its own index
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_a.req   = 4'hF;
    bus_a.cmd   = 8'hAA;
    bus_a.index = 12'h688;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if ((c - 1) % 3 == 0) begin
        exp_ack = 4'(1 << (((c - 1) / 3) % 4));
        exp_j   = 8'(1 << (((c - 1) / 3) % 4));
      end else begin
        exp_ack = 4'h0;
        exp_j   = 8'h00;
      end
      check($sformatf("rr c%0d ack", c),  32'(bus_a.ack),      32'(exp_ack));
      check($sformatf("rr c%0d j", c),    32'(bus_a.signal_j), 32'(exp_j));
      check($sformatf("rr c%0d k", c),    32'(bus_a.signal_k), 32'h0);
      check($sformatf("rr c%0d busy", c), 32'(bus_a.busy),     (c % 3 == 0) ? 32'h0 : 32'h1);
    end
    bus_a.req = 4'h0;
    tick();
    check("rr shadow", 32'(bus_a.shadow), 32'h0F);
    check("rr idle",   32'(bus_a.busy),   32'h0);

    // Out-of-range index on a 6-bit bank
    bus_b.resync = 1'b1;
    bus_b.bank_q = 6'h2A;
    tick();
    bus_b.resync = 1'b0;
    check("oor preload", 32'(bus_b.shadow), 32'h2A);
    bus_b.req   = 4'h1;
    bus_b.cmd   = 8'h03;
    bus_b.index = 12'h007;
    tick();
    check("oor7 ack",    32'(bus_b.ack),      32'h1);
    check("oor7 err",    32'(bus_b.err),      32'h1);
    check("oor7 j",      32'(bus_b.signal_j), 32'h0);
    check("oor7 k",      32'(bus_b.signal_k), 32'h0);
    tick();
    check("oor7 shadow", 32'(bus_b.shadow),   32'h2A);
    check("oor7 err end", 32'(bus_b.err),     32'h0);
    bus_b.req = 4'h0;
    tick();
    bus_b.req   = 4'h1;
    bus_b.cmd   = 8'h03;
    bus_b.index = 12'h005;
    tick();
    check("idx5 err", 32'(bus_b.err),      32'h0);
    check("idx5 j",   32'(bus_b.signal_j), 32'h20);
    check("idx5 k",   32'(bus_b.signal_k), 32'h20);
    tick();
    check("idx5 shadow", 32'(bus_b.shadow), 32'h0A);
    bus_b.req = 4'h0;
    tick();
    bus_b.req   = 4'h1;
    bus_b.cmd   = 8'h02;
    bus_b.index = 12'h006;
    tick();
    check("idx6 ack", 32'(bus_b.ack),      32'h1);
    check("idx6 err", 32'(bus_b.err),      32'h1);
    check("idx6 j",   32'(bus_b.signal_j), 32'h0);
    tick();
    check("idx6 shadow", 32'(bus_b.shadow), 32'h0A);
    bus_b.req = 4'h0;
    tick();

    // Reset in the second gap cycle with GAP_CYCLES=5; requester 2 waits through it
    bus_c.req   = 4'h1;
    bus_c.cmd   = 8'h02;
    bus_c.index = 12'h001;
    tick();
    check("gap5 ack0", 32'(bus_c.ack),      32'h1);
    check("gap5 j0",   32'(bus_c.signal_j), 32'h02);
    tick();
    check("gap5 gap1 busy",   32'(bus_c.busy),   32'h1);
    check("gap5 gap1 shadow", 32'(bus_c.shadow), 32'h02);
    bus_c.req   = 4'h4;
    bus_c.cmd   = 8'h20;
    bus_c.index = 12'h100;
    tick();
    check("gap5 gap2 busy", 32'(bus_c.busy), 32'h1);
    check("gap5 gap2 ack",  32'(bus_c.ack),  32'h0);
    rst_n = 1'b0;
    tick();
    check("gap5 rst busy",   32'(bus_c.busy),     32'h0);
    check("gap5 rst ack",    32'(bus_c.ack),      32'h0);
    check("gap5 rst j",      32'(bus_c.signal_j), 32'h0);
    check("gap5 rst k",      32'(bus_c.signal_k), 32'h0);
    check("gap5 rst shadow", 32'(bus_c.shadow),   32'h0);
    check("gap5 rst err",    32'(bus_c.err),      32'h0);
    rst_n = 1'b1;
    tick();
    check("gap5 req2 ack",  32'(bus_c.ack),      32'h4);
    check("gap5 req2 j",    32'(bus_c.signal_j), 32'h10);
    check("gap5 req2 busy", 32'(bus_c.busy),     32'h1);
    tick();
    bus_c.req = 4'h0;
    check("gap5 req2 shadow", 32'(bus_c.shadow), 32'h10);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
